// File: rtl/wb_shared_bus_if.sv
// Bundle of master-side and slave-side Wishbone signals seen by wb_shared_bus.
// Signal suffixes are from the interconnect's point of view (_i into it, _o out of it).
interface wb_shared_bus_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4
);
  logic [32*NUM_MASTERS-1:0] m_adr_i;
  logic [32*NUM_MASTERS-1:0] m_dat_i;
  logic [4*NUM_MASTERS-1:0]  m_sel_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [31:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [31:0]               s_adr_o;
  logic [31:0]               s_dat_o;
  logic [3:0]                s_sel_o;
  logic                      s_we_o;
  logic [NUM_SLAVES-1:0]     s_cyc_o;
  logic [NUM_SLAVES-1:0]     s_stb_o;
  logic [32*NUM_SLAVES-1:0]  s_dat_i;
  logic [NUM_SLAVES-1:0]     s_ack_i;
  logic [NUM_SLAVES-1:0]     s_err_i;
  logic [NUM_MASTERS-1:0]    grant_o;

  // Interconnect side.
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, grant_o
  );

  // Environment side: the masters and slave devices attached to the bus.
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, grant_o
  );
endinterface

// File: rtl/wb_shared_bus.sv
// Wishbone shared-bus interconnect: round-robin arbitration held for a whole CYC, mask/match decode,
// error response on unmapped addresses. Define WB_BUS_TIMEOUT_EN to add the bus watchdog.
module wb_shared_bus #(
  parameter int                        NUM_MASTERS    = 2,
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_ADDR     = {32'h70010000, 32'h70000000, 32'h40000000, 32'h00000000},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {32'hFFFF0000, 32'hFFFF0000, 32'hE0000000, 32'hF0000000},
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_shared_bus_if.slave bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_masters
    $error("wb_shared_bus: NUM_MASTERS out of range 1..8");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_slaves
    $error("wb_shared_bus: NUM_SLAVES out of range 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_shared_bus: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          last_q;
  logic [NUM_MASTERS-1:0] win_s;
  logic [IW-1:0]          win_idx_s;
  logic                   busy_s;
  logic                   g_cyc_s;
  logic                   g_stb_s;
  logic                   g_we_s;
  logic [31:0]            adr_s;
  logic [31:0]            wdat_s;
  logic [3:0]             bsel_s;
  logic [NUM_SLAVES-1:0]  ssel_s;
  logic                   ssel_vld_s;
  logic [31:0]            rdat_s;
  logic                   ack_s;
  logic                   slv_err_s;
  logic                   unm_s;
  logic                   unm_err_q;
  logic                   unm_seen_q;
  logic [31:0]            unm_adr_q;
  logic                   timeout_err_s;
  logic                   err_s;

  assign busy_s = (state_q == BUSY);

  // Round-robin pick: first requester after last_q, scanning upward with wrap.
  always_comb begin
    logic found_l;
    logic take_l;
    win_s     = '0;
    win_idx_s = '0;
    found_l   = 1'b0;
    take_l    = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        take_l    = ~found_l & bus.m_cyc_i[j] &
                    (int'(last_q) == ((j - i + NUM_MASTERS) % NUM_MASTERS));
        win_s[j]  = win_s[j] | take_l;
        win_idx_s = take_l ? IW'(j) : win_idx_s;
        found_l   = found_l | take_l;
      end
    end
  end

  // Arbitration FSM; the grant is held until the owner drops CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.m_cyc_i) begin
            state_q <= BUSY;
            grant_q <= win_s;
            last_q  <= win_idx_s;
          end
        end
        BUSY: begin
          if (!g_cyc_s) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Master-to-slave mux; grant_q is all-zero in IDLE so every field reads 0.
  always_comb begin
    adr_s  = 32'h0;
    wdat_s = 32'h0;
    bsel_s = 4'h0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      adr_s  = adr_s  | (grant_q[i] ? bus.m_adr_i[i*32 +: 32] : 32'h0);
      wdat_s = wdat_s | (grant_q[i] ? bus.m_dat_i[i*32 +: 32] : 32'h0);
      bsel_s = bsel_s | (grant_q[i] ? bus.m_sel_i[i*4 +: 4]   : 4'h0);
    end
  end

  assign g_cyc_s = |(bus.m_cyc_i & grant_q);
  assign g_stb_s = |(bus.m_stb_i & grant_q);
  assign g_we_s  = |(bus.m_we_i  & grant_q);

  // Address decode; lowest matching slave wins on overlap.
  always_comb begin
    logic found_l;
    logic hit_l;
    ssel_s  = '0;
    found_l = 1'b0;
    hit_l   = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      hit_l     = ((adr_s & SLAVE_MASK[k*32 +: 32]) == SLAVE_ADDR[k*32 +: 32]);
      ssel_s[k] = busy_s & ~found_l & hit_l;
      found_l   = found_l | hit_l;
    end
    ssel_vld_s = busy_s & found_l;
  end

  // Read-data return from the selected slave.
  always_comb begin
    rdat_s = 32'h0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rdat_s = rdat_s | (ssel_s[k] ? bus.s_dat_i[k*32 +: 32] : 32'h0);
    end
  end

  assign ack_s     = |(bus.s_ack_i & ssel_s);
  assign slv_err_s = |(bus.s_err_i & ssel_s);
  assign unm_s     = busy_s & g_stb_s & ~ssel_vld_s;

  // One error pulse per unmapped strobe; re-armed when stb drops or the address moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unm_err_q  <= 1'b0;
      unm_seen_q <= 1'b0;
      unm_adr_q  <= 32'h0;
    end else begin
      unm_err_q  <= unm_s & ~(unm_seen_q & (adr_s == unm_adr_q));
      unm_seen_q <= unm_s;
      unm_adr_q  <= adr_s;
    end
  end

`ifdef WB_BUS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        to_q;

  // Watchdog: counts unanswered strobe cycles and fires a single error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 16'h0;
      to_q     <= 1'b0;
    end else if (!busy_s || !g_stb_s || ack_s || slv_err_s || unm_s) begin
      to_cnt_q <= 16'h0;
      to_q     <= 1'b0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_q <= 16'h0;
      to_q     <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_q + 16'h1;
      to_q     <= 1'b0;
    end
  end

  // A slave ack arriving together with the timeout wins.
  assign timeout_err_s = to_q & ~ack_s;
`else
  assign timeout_err_s = 1'b0;
`endif

  assign err_s = slv_err_s | unm_err_q | timeout_err_s;

  assign bus.s_adr_o = adr_s;
  assign bus.s_dat_o = wdat_s;
  assign bus.s_sel_o = bsel_s;
  assign bus.s_we_o  = g_we_s;
  assign bus.s_cyc_o = ssel_s & {NUM_SLAVES{g_cyc_s}};
  assign bus.s_stb_o = ssel_s & {NUM_SLAVES{g_stb_s}};
  assign bus.m_dat_o = rdat_s;
  assign bus.m_ack_o = ack_s ? grant_q : '0;
  assign bus.m_err_o = err_s ? grant_q : '0;
  assign bus.grant_o = grant_q;
endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed self-checking bench for wb_shared_bus: arbitration, decode, write path, unmapped error,
// reset mid-transfer, and the watchdog when WB_BUS_TIMEOUT_EN is defined.
module tb_wb_shared_bus;
  localparam int NM = 2;
  localparam int NS = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [NS-1:0] ack_q;
  logic [NS-1:0] ack_en;

  always #5 clk = ~clk;

  wb_shared_bus_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus ();

  wb_shared_bus #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Slave stubs: ack one cycle after strobe when enabled, fixed read data per slave.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= '0;
    else        ack_q <= bus.s_stb_o & ~ack_q & ack_en;
  end

  assign bus.s_ack_i = ack_q;
  assign bus.s_err_i = '0;
  assign bus.s_dat_i = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.m_cyc_i[m]          = cyc;
    bus.m_stb_i[m]          = cyc;
    bus.m_we_i[m]           = we;
    bus.m_adr_i[m*32 +: 32] = adr;
    bus.m_dat_i[m*32 +: 32] = dat;
    bus.m_sel_i[m*4 +: 4]   = sel;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_grant"}, 32'(bus.grant_o), 32'h0);
    check_eq({tag, "_scyc"},  32'(bus.s_cyc_o), 32'h0);
    check_eq({tag, "_sstb"},  32'(bus.s_stb_o), 32'h0);
    check_eq({tag, "_sadr"},  bus.s_adr_o,      32'h0);
    check_eq({tag, "_sdat"},  bus.s_dat_o,      32'h0);
    check_eq({tag, "_ssel"},  32'(bus.s_sel_o), 32'h0);
    check_eq({tag, "_swe"},   32'(bus.s_we_o),  32'h0);
    check_eq({tag, "_mdat"},  bus.m_dat_o,      32'h0);
    check_eq({tag, "_mack"},  32'(bus.m_ack_o), 32'h0);
    check_eq({tag, "_merr"},  32'(bus.m_err_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ack_en = 4'b1111;
    // Requests present during reset must not leak to any output.
    set_m(0, 1'b1, 1'b1, 32'h00000010, 32'hA5A5A5A5, 4'hF);
    set_m(1, 1'b1, 1'b0, 32'h70000004, 32'h5A5A5A5A, 4'h3);
    #12;
    check_all_zero("reset");
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;

    // Simultaneous requests: grant alternates starting with master 0.
    for (int r = 0; r < 4; r++) begin
      tick();
      set_m(0, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF);
      set_m(1, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF);
      tick();
      smp();
      check_eq("rr_grant", 32'(bus.grant_o), (r % 2 == 0) ? 32'h1 : 32'h2);
      check_eq("rr_onehot", 32'($countones(bus.grant_o)), 32'h1);
      tick();
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      tick();
    end

    // Single read from bram with one-cycle arbitration latency.
    tick();
    set_m(0, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF);
    smp();
    check_eq("rd_lat_scyc", 32'(bus.s_cyc_o), 32'h0);
    tick();
    smp();
    check_eq("rd_scyc",  32'(bus.s_cyc_o), 32'h1);
    check_eq("rd_grant", 32'(bus.grant_o), 32'h1);
    check_eq("rd_ack0",  32'(bus.m_ack_o), 32'h0);
    tick();
    smp();
    check_eq("rd_ack",  32'(bus.m_ack_o), 32'h1);
    check_eq("rd_mdat", bus.m_dat_o,      32'hDEADBEEF);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    smp();
    check_eq("rd_idle", 32'(bus.grant_o), 32'h0);

    // Master 1 writes the uart while master 0 waits its turn.
    tick();
    set_m(0, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 32'h70000004, 32'h00000041, 4'h1);
    tick();
    smp();
    check_eq("wr_grant", 32'(bus.grant_o), 32'h2);
    check_eq("wr_scyc",  32'(bus.s_cyc_o), 32'h4);
    check_eq("wr_swe",   32'(bus.s_we_o),  32'h1);
    check_eq("wr_ssel",  32'(bus.s_sel_o), 32'h1);
    check_eq("wr_sdat",  bus.s_dat_o,      32'h41);
    check_eq("wr_sadr",  bus.s_adr_o,      32'h70000004);
    check_eq("wr_ack0",  32'(bus.m_ack_o), 32'h0);
    tick();
    smp();
    check_eq("wr_ack",  32'(bus.m_ack_o), 32'h2);
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    smp();
    check_eq("wr_rel_idle", 32'(bus.grant_o), 32'h0);
    tick();
    smp();
    check_eq("m0_grant", 32'(bus.grant_o), 32'h1);
    check_eq("m0_scyc",  32'(bus.s_cyc_o), 32'h1);
    check_eq("m0_swe",   32'(bus.s_we_o),  32'h0);
    tick();
    smp();
    check_eq("m0_ack", 32'(bus.m_ack_o), 32'h1);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();

    // Unmapped address: no slave selected, exactly one error pulse.
    tick();
    set_m(0, 1'b1, 1'b0, 32'h90000000, 32'h0, 4'hF);
    tick();
    smp();
    check_eq("unm_scyc",  32'(bus.s_cyc_o), 32'h0);
    check_eq("unm_sadr",  bus.s_adr_o,      32'h90000000);
    check_eq("unm_err0",  32'(bus.m_err_o), 32'h0);
    tick();
    smp();
    check_eq("unm_err1",  32'(bus.m_err_o), 32'h1);
    check_eq("unm_ack",   32'(bus.m_ack_o), 32'h0);
    tick();
    smp();
    check_eq("unm_err2",  32'(bus.m_err_o), 32'h0);
    tick();
    smp();
    check_eq("unm_err3",  32'(bus.m_err_o), 32'h0);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();

`ifdef WB_BUS_TIMEOUT_EN
    // Silent slave 3: error pulse after TO strobe cycles, then bus released.
    ack_en = 4'b0111;
    tick();
    set_m(0, 1'b1, 1'b0, 32'h70010000, 32'h0, 4'hF);
    tick();
    for (int i = 1; i <= TO; i++) begin
      smp();
      check_eq("to_quiet", 32'(bus.m_err_o), 32'h0);
      tick();
    end
    smp();
    check_eq("to_pulse", 32'(bus.m_err_o), 32'h1);
    tick();
    smp();
    check_eq("to_after", 32'(bus.m_err_o), 32'h0);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    smp();
    check_eq("to_idle", 32'(bus.grant_o), 32'h0);
    ack_en = 4'b1111;
`endif

    // Reset while a transfer is in flight, then a fresh master 1 request.
    ack_en = 4'b1110;
    tick();
    set_m(0, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF);
    tick();
    smp();
    check_eq("mid_scyc", 32'(bus.s_cyc_o), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b1, 1'b0, 32'h00000010, 32'h0, 4'hF);
    #1;
    rst_n = 1'b1;
    tick();
    smp();
    check_eq("post_rst_grant", 32'(bus.grant_o), 32'h2);
    check_eq("post_rst_scyc",  32'(bus.s_cyc_o), 32'h1);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
